// File: rtl/llc_tag_match_stage_pkg.sv
// Shared LLC tag-match constants and the S1/result bundles.
// The result bundle is the record handed to the process stage.
package llc_tag_match_stage_pkg;

  localparam int LLC_WAYS       = 16;
  localparam int LLC_WAY_BITS   = $clog2(LLC_WAYS);
  localparam int LLC_TAG_BITS   = 15;
  localparam int LLC_STATE_BITS = 3;
  localparam int LLC_SET_BITS   = 9;
  localparam int LLC_CTRL_BITS  = 8;
  localparam int LLC_CNT_BITS   = 16;

  localparam logic [LLC_STATE_BITS-1:0] LLC_INVALID = '0;

  typedef struct packed {
    logic [LLC_WAYS-1:0]      match;
    logic [LLC_WAYS-1:0]      invalid;
    logic [LLC_WAY_BITS-1:0]  evict_way;
    logic [LLC_SET_BITS-1:0]  set_idx;
    logic [LLC_TAG_BITS-1:0]  tag;
    logic [LLC_CTRL_BITS-1:0] ctrl;
  } llc_s1_t;

  typedef struct packed {
    logic                     hit;
    logic [LLC_WAY_BITS-1:0]  way;
    logic                     empty_found;
    logic [LLC_WAY_BITS-1:0]  empty_way;
    logic [LLC_WAY_BITS-1:0]  evict_way;
    logic [LLC_SET_BITS-1:0]  set_idx;
    logic [LLC_TAG_BITS-1:0]  tag;
    logic [LLC_CTRL_BITS-1:0] ctrl;
  } llc_tm_res_t;

endpackage

// File: rtl/llc_tag_match_stage_prio_enc.sv
// Lowest-index-wins priority encoder over a per-way flag vector.
// Reports index 0 when no flag is set.
module llc_way_prio_enc #(
  parameter int WAYS     = 16,
  parameter int WAY_BITS = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]     vec,
  output logic                found,
  output logic [WAY_BITS-1:0] idx
);

  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = WAY_BITS'(i);
    end
  end

endmodule

// File: rtl/llc_tag_match_stage.sv
// Two-stage LLC tag match: S1 compares tags, S2 encodes results.
// Valid/ready on both sides, plus saturating hit/miss counters.
module llc_tag_match_stage
  import llc_tag_match_stage_pkg::*;
#(
  parameter int WAYS       = LLC_WAYS,
  parameter int WAY_BITS   = $clog2(WAYS),
  parameter int TAG_BITS   = LLC_TAG_BITS,
  parameter int STATE_BITS = LLC_STATE_BITS,
  parameter int SET_BITS   = LLC_SET_BITS,
  parameter int CTRL_BITS  = LLC_CTRL_BITS,
  parameter int CNT_BITS   = LLC_CNT_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         clr_cnt,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SET_BITS-1:0]          in_set,
  input  logic [TAG_BITS-1:0]          in_tag,
  input  logic [CTRL_BITS-1:0]         in_ctrl,
  input  logic [WAYS*TAG_BITS-1:0]     in_tags,
  input  logic [WAYS*STATE_BITS-1:0]   in_states,
  input  logic [WAY_BITS-1:0]          in_evict_way,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SET_BITS-1:0]          out_set,
  output logic [TAG_BITS-1:0]          out_tag,
  output logic [CTRL_BITS-1:0]         out_ctrl,
  output logic                         out_hit,
  output logic [WAY_BITS-1:0]          out_way,
  output logic                         out_empty_found,
  output logic [WAY_BITS-1:0]          out_empty_way,
  output logic [WAY_BITS-1:0]          out_evict_way,
  output logic [CNT_BITS-1:0]          hit_cnt,
  output logic [CNT_BITS-1:0]          miss_cnt
);

  llc_s1_t     s1_q;
  llc_tm_res_t res_q;
  llc_tm_res_t res_d;
  logic        s1_valid;
  logic        s2_valid;
  logic        s1_load;
  logic        s2_load;
  logic        fire;

  logic [WAYS-1:0]     match;
  logic [WAYS-1:0]     invalid;
  logic                hit_found;
  logic [WAY_BITS-1:0] hit_way;
  logic                empty_found;
  logic [WAY_BITS-1:0] empty_way;

  always_comb begin
    match   = '0;
    invalid = '0;
    for (int i = 0; i < WAYS; i++) begin
      invalid[i] = in_states[i*STATE_BITS +: STATE_BITS] == LLC_INVALID;
      match[i]   = !invalid[i] &&
                   in_tags[i*TAG_BITS +: TAG_BITS] == in_tag;
    end
  end

  assign in_ready = !flush &&
                    (!s1_valid || !s2_valid || out_ready);
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign fire     = s2_valid && out_ready;

  llc_way_prio_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_hit_enc (
    .vec   (s1_q.match),
    .found (hit_found),
    .idx   (hit_way)
  );

  llc_way_prio_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_empty_enc (
    .vec   (s1_q.invalid),
    .found (empty_found),
    .idx   (empty_way)
  );

  always_comb begin
    res_d             = '0;
    res_d.hit         = hit_found;
    res_d.empty_found = empty_found;
    res_d.empty_way   = empty_way;
    res_d.evict_way   = empty_found ? empty_way : s1_q.evict_way;
    res_d.way         = hit_found ? hit_way : res_d.evict_way;
    res_d.set_idx     = s1_q.set_idx;
    res_d.tag         = s1_q.tag;
    res_d.ctrl        = s1_q.ctrl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load)      s2_valid <= 1'b1;
      else if (fire)    s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      res_q <= '0;
    end else begin
      if (s1_load) begin
        s1_q.match     <= match;
        s1_q.invalid   <= invalid;
        s1_q.evict_way <= in_evict_way;
        s1_q.set_idx   <= in_set;
        s1_q.tag       <= in_tag;
        s1_q.ctrl      <= in_ctrl;
      end
      if (s2_load) res_q <= res_d;
    end
  end

  // A handshake in a flush cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_cnt) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (fire) begin
      if (res_q.hit && hit_cnt != '1)
        hit_cnt <= hit_cnt + 1'b1;
      if (!res_q.hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
    end
  end

  assign out_valid       = s2_valid;
  assign out_set         = res_q.set_idx;
  assign out_tag         = res_q.tag;
  assign out_ctrl        = res_q.ctrl;
  assign out_hit         = res_q.hit;
  assign out_way         = res_q.way;
  assign out_empty_found = res_q.empty_found;
  assign out_empty_way   = res_q.empty_way;
  assign out_evict_way   = res_q.evict_way;

endmodule

// File: tb/tb_llc_tag_match_stage.sv
// Bench for llc_tag_match_stage: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_llc_tag_match_stage;

  localparam int W  = 16;
  localparam int TB = 15;
  localparam int SB = 3;
  localparam int TW = W * TB;
  localparam int SW = W * SB;

  logic           clk, rst, flush, clr_cnt;
  logic           in_valid, in_ready;
  logic [8:0]     in_set;
  logic [14:0]    in_tag;
  logic [7:0]     in_ctrl;
  logic [TW-1:0]  in_tags;
  logic [SW-1:0]  in_states;
  logic [3:0]     in_evict_way;
  logic           out_valid, out_ready;
  logic [8:0]     out_set;
  logic [14:0]    out_tag;
  logic [7:0]     out_ctrl;
  logic           out_hit;
  logic [3:0]     out_way;
  logic           out_empty_found;
  logic [3:0]     out_empty_way;
  logic [3:0]     out_evict_way;
  logic [15:0]    hit_cnt, miss_cnt;

  llc_tag_match_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_set(in_set), .in_tag(in_tag), .in_ctrl(in_ctrl),
    .in_tags(in_tags), .in_states(in_states),
    .in_evict_way(in_evict_way),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_set(out_set), .out_tag(out_tag), .out_ctrl(out_ctrl),
    .out_hit(out_hit), .out_way(out_way),
    .out_empty_found(out_empty_found),
    .out_empty_way(out_empty_way),
    .out_evict_way(out_evict_way),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic [3:0] way;
    logic       ef;
    logic [3:0] ew;
    logic [3:0] ev;
    logic [8:0] set_idx;
    logic [14:0] tag;
    logic [7:0] ctrl;
  } res_t;

  typedef struct {
    logic [8:0]    set_idx;
    logic [14:0]   tag;
    logic [7:0]    ctrl;
    logic [TW-1:0] tags;
    logic [SW-1:0] states;
    logic [3:0]    ev;
  } pkt_t;

  typedef struct {
    pkt_t p;
    res_t exp;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  int   hits_m = 0;
  int   miss_m = 0;
  pkt_t cur;
  res_t got;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan the set as the LLC would, lowest way first.
  function automatic res_t model(pkt_t p);
    res_t r;
    int hw = -1;
    int ew = -1;
    for (int i = 0; i < W; i++) begin
      if (p.states[i*SB +: SB] == 3'd0) begin
        if (ew < 0) ew = i;
      end else if (p.tags[i*TB +: TB] == p.tag) begin
        if (hw < 0) hw = i;
      end
    end
    r.ef      = ew >= 0;
    r.ew      = r.ef ? 4'(ew) : 4'd0;
    r.ev      = r.ef ? 4'(ew) : p.ev;
    r.hit     = hw >= 0;
    r.way     = r.hit ? 4'(hw) : r.ev;
    r.set_idx = p.set_idx;
    r.tag     = p.tag;
    r.ctrl    = p.ctrl;
    return r;
  endfunction

  function automatic pkt_t base_pkt(int tbase, int st);
    pkt_t p;
    for (int i = 0; i < W; i++) begin
      p.tags[i*TB +: TB]   = 15'(tbase + i);
      p.states[i*SB +: SB] = 3'(st);
    end
    p.tag     = 15'h1A2;
    p.set_idx = 9'($urandom);
    p.ctrl    = 8'($urandom);
    p.ev      = 4'd0;
    return p;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    logic full = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < W; i++) begin
      p.tags[i*TB +: TB]   = 15'($urandom_range(0, 3));
      p.states[i*SB +: SB] = full ? 3'($urandom_range(1, 7))
                                  : 3'($urandom_range(0, 3));
    end
    p.tag     = 15'($urandom_range(0, 3));
    p.set_idx = 9'($urandom);
    p.ctrl    = 8'($urandom);
    p.ev      = 4'($urandom);
    return p;
  endfunction

  task automatic drive(pkt_t p, logic v);
    cur          = p;
    in_valid     = v;
    in_set       = p.set_idx;
    in_tag       = p.tag;
    in_ctrl      = p.ctrl;
    in_tags      = p.tags;
    in_states    = p.states;
    in_evict_way = p.ev;
  endtask

  function automatic res_t out_now();
    res_t r;
    r.hit = out_hit;       r.way = out_way;
    r.ef  = out_empty_found; r.ew = out_empty_way;
    r.ev  = out_evict_way; r.set_idx = out_set;
    r.tag = out_tag;       r.ctrl = out_ctrl;
    return r;
  endfunction

  // One cycle: sample handshakes before the edge, update model after.
  task automatic step(output logic acc, output logic fire);
    res_t exp;
    logic fl, clr;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    got  = out_now();
    fl   = flush;
    clr  = clr_cnt;
    @(posedge clk);
    if (fire) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(got), 64'hDEAD);
      end else begin
        exp = exp_q.pop_front();
        chk("result", 64'(got), 64'(exp));
      end
    end
    if (clr) begin
      hits_m = 0;
      miss_m = 0;
    end else if (fire) begin
      if (got.hit) hits_m = (hits_m == 65535) ? 65535 : hits_m + 1;
      else         miss_m = (miss_m == 65535) ? 65535 : miss_m + 1;
    end
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(model(cur));
    @(negedge clk);
    chk("hit_cnt", 64'(hit_cnt), 64'(hits_m));
    chk("miss_cnt", 64'(miss_cnt), 64'(miss_m));
  endtask

  vec_t tbl[5];
  pkt_t p;
  pkt_t bp[4];
  logic a, f;
  res_t held;
  logic have;
  int   idx;
  int   fires;
  logic pend;

  initial begin
    // Directed vectors with hand-derived expected results.
    p = base_pkt(15'h100, 0);
    p.tags[5*TB +: TB] = 15'h1A2;
    p.states[5*SB +: SB] = 3'd1;
    p.ev = 4'd4;
    tbl[0] = '{p, '{1'b1, 4'd5, 1'b1, 4'd0, 4'd0,
                    p.set_idx, p.tag, p.ctrl}};
    p = base_pkt(15'h200, 1);
    p.ev = 4'd9;
    tbl[1] = '{p, '{1'b0, 4'd9, 1'b0, 4'd0, 4'd9,
                    p.set_idx, p.tag, p.ctrl}};
    p = base_pkt(15'h300, 2);
    p.tags[3*TB +: TB] = 15'h1A2;
    p.states[3*SB +: SB] = 3'd0;
    p.states[7*SB +: SB] = 3'd0;
    p.ev = 4'd12;
    tbl[2] = '{p, '{1'b0, 4'd3, 1'b1, 4'd3, 4'd3,
                    p.set_idx, p.tag, p.ctrl}};
    p = base_pkt(15'h400, 4);
    p.tags[2*TB +: TB]  = 15'h1A2;
    p.tags[11*TB +: TB] = 15'h1A2;
    p.states[2*SB +: SB]  = 3'd5;
    p.states[11*SB +: SB] = 3'd5;
    p.states[14*SB +: SB] = 3'd0;
    p.ev = 4'd1;
    tbl[3] = '{p, '{1'b1, 4'd2, 1'b1, 4'd14, 4'd14,
                    p.set_idx, p.tag, p.ctrl}};
    p = base_pkt(15'h500, 6);
    p.tags[15*TB +: TB] = 15'h1A2;
    p.ev = 4'd6;
    tbl[4] = '{p, '{1'b1, 4'd15, 1'b0, 4'd0, 4'd6,
                    p.set_idx, p.tag, p.ctrl}};

    rst = 1'b1; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
    drive(tbl[0].p, 1'b0);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_hit", 64'(out_hit), 64'd0);
    chk("rst_out_way", 64'(out_way), 64'd0);
    chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      drive(tbl[k].p, 1'b1);
      step(a, f);
      chk("tbl_accept", 64'(a), 64'd1);
      in_valid = 1'b0;
      step(a, f);
      chk("tbl_latency", 64'(out_valid), 64'd1);
      chk("tbl_result", 64'(out_now()), 64'(tbl[k].exp));
      step(a, f);
      if (k == 0) chk("tbl_hit_cnt", 64'(hit_cnt), 64'd1);
      if (k == 1) chk("tbl_miss_cnt", 64'(miss_cnt), 64'd1);
    end

    // Backpressure: 4 back-to-back packets, 5 stalled cycles.
    for (int i = 0; i < 4; i++) bp[i] = rand_pkt();
    idx = 0; have = 1'b0; held = '0;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 5);
      if (idx < 4) drive(bp[idx], 1'b1);
      else         in_valid = 1'b0;
      step(a, f);
      if (a) idx++;
      if (c < 5 && out_valid) begin
        if (!have) begin
          held = out_now();
          have = 1'b1;
        end else begin
          chk("bp_held", 64'(out_now()), 64'(held));
        end
      end
      if (c == 4) chk("bp_accepted", 64'(idx), 64'd2);
    end
    chk("bp_all_in", 64'(idx), 64'd4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush with both stages full and an output handshake.
    out_ready = 1'b0;
    drive(rand_pkt(), 1'b1); step(a, f);
    drive(rand_pkt(), 1'b1); step(a, f);
    drive(rand_pkt(), 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    step(a, f);
    chk("flush_in_ready", 64'(a), 64'd0);
    chk("flush_fire", 64'(f), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(a, f);
      chk("flush_quiet", 64'(out_valid), 64'd0);
    end

    // Hit counter saturation, then clear racing a hit.
    clr_cnt = 1'b1; step(a, f); clr_cnt = 1'b0;
    p = base_pkt(15'h600, 1);
    for (int i = 0; i < W; i++) p.tags[i*TB +: TB] = 15'h1A2;
    drive(p, 1'b1);
    out_ready = 1'b1;
    fires = 0;
    for (int i = 0; i < 70000 && fires < 65536; i++) begin
      step(a, f);
      if (f) fires++;
    end
    chk("sat_fires", 64'(fires), 64'd65536);
    chk("sat_hit_cnt", 64'(hit_cnt), 64'hFFFF);
    clr_cnt = 1'b1;
    step(a, f);
    clr_cnt = 1'b0;
    chk("clr_fire", 64'(f), 64'd1);
    chk("clr_hit_cnt", 64'(hit_cnt), 64'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(a, f);

    // Random traffic.
    pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) drive(rand_pkt(), $urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 29) == 0;
      clr_cnt   = $urandom_range(0, 49) == 0;
      step(a, f);
      pend = in_valid && !a;
    end
    flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(a, f);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of traffic.
    out_ready = 1'b0;
    drive(rand_pkt(), 1'b1); step(a, f);
    drive(rand_pkt(), 1'b1); step(a, f);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("arst_miss_cnt", 64'(miss_cnt), 64'd0);
    exp_q.delete();
    hits_m = 0; miss_m = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(a, f);
      chk("arst_quiet", 64'(out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/llc_tag_match_stage.md
Name: llc_tag_match_stage

Overview:
Two-stage pipelined tag-match stage of the LLC pipeline. It sits directly downstream of the local-memory read, between the mem-to-lookup FIFO and the process stage.
- Consumes one set read: per-way tags and states, plus the request tag, set and opaque control bits.
- Produces hit/miss, hit way, first empty way and chosen evict way, with valid/ready handshakes on both sides.
- Keeps saturating hit/miss statistics counters.

Parameters:
WAYS, 16, number of LLC ways (power of 2)
WAY_BITS, $clog2(WAYS), way index width
TAG_BITS, 15, LLC tag width
STATE_BITS, 3, LLC line state width
SET_BITS, 9, LLC set index width
CTRL_BITS, 8, opaque sideband (is_*_to_get/resume flags), passed through unchanged
CNT_BITS, 16, statistics counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline clear
clr_cnt  in  1  synchronous clear of hit_cnt/miss_cnt
in_valid  in  1  input packet valid
in_ready  out  1  stage accepts input this cycle
in_set  in  SET_BITS  set index
in_tag  in  TAG_BITS  request tag
in_ctrl  in  CTRL_BITS  sideband
in_tags  in  WAYS*TAG_BITS  way i at [i*TAG_BITS +: TAG_BITS]
in_states  in  WAYS*STATE_BITS  way i at [i*STATE_BITS +: STATE_BITS]
in_evict_way  in  WAY_BITS  round-robin evict pointer for this set
out_valid  out  1  result valid
out_ready  in  1  process stage accepts result
out_set  out  SET_BITS  registered copy of in_set
out_tag  out  TAG_BITS  registered copy of in_tag
out_ctrl  out  CTRL_BITS  registered copy of in_ctrl
out_hit  out  1  tag match on a non-INVALID way
out_way  out  WAY_BITS  hit way if hit, else out_evict_way
out_empty_found  out  1  at least one INVALID way
out_empty_way  out  WAY_BITS  lowest-index INVALID way (0 if none)
out_evict_way  out  WAY_BITS  out_empty_way if out_empty_found, else in_evict_way
hit_cnt  out  CNT_BITS  saturating hit count
miss_cnt  out  CNT_BITS  saturating miss count

Behaviour:
- Reset (rst=1, async): s1_valid=0, s2_valid=0, all registered outputs 0, counters 0, in_ready=1 after deassertion.
- S1 stage:
  - match[i] = (tag_i==in_tag) && (state_i != INVALID); invalid[i] = (state_i == INVALID).
  - Registers match, invalid, in_evict_way and sideband.
- S2 stage: priority-encodes match and invalid (lowest index wins) and registers all out_* fields.
- Multiple matching ways are legal: the lowest index is reported, no error.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !flush && (!s1_valid || !s2_valid || out_ready).
- Throughput is 1 packet/cycle with out_ready held high. Latency is 2 cycles, input handshake to out_valid.
- Backpressure: out_* are held stable while out_valid && !out_ready. S1 holds its packet; no packet is dropped or duplicated.
- flush=1: s1_valid and s2_valid clear next edge, and in_ready=0 that cycle. An output handshake in the flush cycle still completes and is counted.
- Counters:
  - On out_valid && out_ready: hit_cnt+1 if out_hit, else miss_cnt+1.
  - Saturate at 2^CNT_BITS-1; no wrap.
  - clr_cnt has priority over an increment in the same cycle.
  - flush does not touch the counters.
- Reset mid-operation discards all in-flight packets immediately.

Decomposition:
- cache_consts.svh: LLC_INVALID state encoding; default widths taken from LLC_WAYS, LLC_TAG_BITS, LLC_STATE_BITS, LLC_SET_BITS.
- cache_types.svh: packed struct for the S1→S2 register, and the packed output result struct shared with the process stage.
- One sub-module, llc_way_prio_enc (WAYS-bit vector → found flag + lowest set index), instantiated twice in S2.

Test Plan:
- Hit: in_tag=0x1A2, way 5 tag 0x1A2 state VALID, others INVALID → 2 cycles later out_hit=1, out_way=5, out_empty_found=1, out_empty_way=0, hit_cnt=1.
- Full-set miss: all 16 ways VALID, none match, in_evict_way=9 → out_hit=0, out_empty_found=0, out_evict_way=9, out_way=9, miss_cnt=1.
- Tag match on INVALID way 3, way 7 also INVALID → out_hit=0, out_empty_way=3, out_way=3.
- Backpressure: 4 back-to-back packets with out_ready low for 5 cycles → in_ready drops after 2 accepted; all 4 emerge in order with held values, none lost.
- Flush with both stages full, plus out_ready=1 in the same cycle → the S2 packet is counted, out_valid=0 next cycle, the S1 packet never appears.
- Counter saturation: preload via 65535 hits, then one more hit → hit_cnt stays 0xFFFF; clr_cnt together with a hit → hit_cnt=0.
